pe_inst_loader: RTL and testbench

Write-side companion to the PE instruction FIFO. It accepts packed instruction words from the memory-interface bus, unpacks them into individual instructions, and writes them sequentially from address 0 into the PE instruction buffer. A load always ends with the all-zero terminator that the PE read side uses to detect the last instruction and restart. The loader also reports completion, the instruction count and any overflow to the PE controller.

---
 rtl/pe_inst_loader_pkg.sv | 28 ++
 rtl/pe_inst_loader_if.sv | 21 ++
 rtl/pe_inst_loader_unpacker.sv | 48 ++++
 rtl/pe_inst_loader.sv | 143 ++++++++++++++
 tb/tb_pe_inst_loader.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_inst_loader_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : pe_inst_pkg                                                      |
// | Desc    : Shared FSM encoding, lane geometry and terminator constant.      |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package pe_inst_pkg;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_RECV = 2'd1;
  localparam logic [1:0] c_ST_EMIT = 2'd2;
  localparam logic [1:0] c_ST_DONE = 2'd3;

  // Replicated to instLen bits at the point of use to form the all-zero word.
  localparam bit c_TERM_BIT = 1'b0;

  function automatic int f_ratio(input int bus_len, input int inst_len);
    return bus_len / inst_len;
  endfunction

  function automatic int f_lane_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pe_inst_loader_if.sv
// +----------------------------------------------------------------------------+
// | Module  : pe_inst_bus_if                                                   |
// | Desc    : Memory-interface bus handshake carrying packed instruction words.|
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface pe_inst_bus_if #(
  parameter int busLen = 64
);

  logic              bus_valid;
  logic [busLen-1:0] bus_data;
  logic              bus_ready;

  modport master (output bus_valid, output bus_data, input  bus_ready);
  modport slave  (input  bus_valid, input  bus_data, output bus_ready);

endinterface

`default_nettype wire

// File: rtl/pe_inst_loader_unpacker.sv
// +----------------------------------------------------------------------------+
// | Module  : pe_inst_unpacker                                                 |
// | Desc    : Bus-word shift register presenting one instruction lane at a time|
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module pe_inst_unpacker
  import pe_inst_pkg::*;
#(
  parameter int busLen  = 64,
  parameter int instLen = 32
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               i_load,
  input  wire logic               i_shift,
  input  wire logic [busLen-1:0]  i_data,
  output logic      [instLen-1:0] o_lane,
  output logic                    o_last_lane
);

  localparam int c_RATIO  = f_ratio(busLen, instLen);
  localparam int c_LANE_W = f_lane_w(c_RATIO);
  localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(c_RATIO - 1);

  logic [busLen-1:0]   r_shreg;
  logic [c_LANE_W-1:0] r_lane;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg <= '0;
      r_lane  <= '0;
    end else if (i_load) begin
      r_shreg <= i_data;
      r_lane  <= '0;
    end else if (i_shift) begin
      r_shreg <= r_shreg >> instLen;
      r_lane  <= r_lane + 1'b1;
    end
  end

  assign o_lane      = r_shreg[instLen-1:0];
  assign o_last_lane = (r_lane == c_LAST_LANE);

endmodule

`default_nettype wire

// File: rtl/pe_inst_loader.sv
// +----------------------------------------------------------------------------+
// | Module  : pe_inst_loader                                                   |
// | Desc    : Unpacks bus words into the PE instruction buffer, terminator-    |
// |           ended. Optional INST_LOADER_CHECKSUM_EN adds an XOR checksum.    |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module pe_inst_loader
  import pe_inst_pkg::*;
#(
  parameter int instAddrLen = 6,
  parameter int instLen     = 32,
  parameter int busLen      = 64,
  parameter int peId        = 0
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  input  wire logic                   i_load_start,
  pe_inst_bus_if.slave                bus,
  output logic                        o_inst_wrt,
  output logic [instAddrLen-1:0]      o_inst_wrt_addr,
  output logic [instLen-1:0]          o_inst_wrt_data,
  output logic                        o_load_busy,
  output logic                        o_load_done,
  output logic                        o_load_error,
`ifdef INST_LOADER_CHECKSUM_EN
  output logic [instLen-1:0]          o_inst_checksum,
`endif
  output logic [instAddrLen:0]        o_inst_count
);

  localparam logic [instAddrLen-1:0] c_ADDR_MAX = '1;

  logic [1:0]             r_state;
  logic [instAddrLen-1:0] r_addr;
  logic                   r_wrt;
  logic [instAddrLen-1:0] r_wrt_addr;
  logic [instLen-1:0]     r_wrt_data;
  logic                   r_error;
  logic [instAddrLen:0]   r_count;

  logic [instLen-1:0]     w_lane;
  logic                   w_last_lane;
  logic                   w_accept;
  logic                   w_emit;
  logic                   w_is_term;
  logic                   w_overflow;
  logic [instLen-1:0]     w_wdata;

  assign w_accept   = bus.bus_valid && (r_state == c_ST_RECV);
  assign w_emit     = (r_state == c_ST_EMIT);
  assign w_is_term  = (w_lane == {instLen{c_TERM_BIT}});
  assign w_overflow = w_emit && !w_is_term && (r_addr == c_ADDR_MAX);
  // The last buffer slot must hold the terminator, so an overflowing lane is replaced by zero.
  assign w_wdata    = w_overflow ? {instLen{c_TERM_BIT}} : w_lane;

  pe_inst_unpacker #(
    .busLen  (busLen),
    .instLen (instLen)
  ) u_unpacker (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_accept),
    .i_shift     (w_emit),
    .i_data      (bus.bus_data),
    .o_lane      (w_lane),
    .o_last_lane (w_last_lane)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_ST_IDLE;
      r_addr     <= '0;
      r_wrt      <= 1'b0;
      r_wrt_addr <= '0;
      r_wrt_data <= '0;
      r_error    <= 1'b0;
      r_count    <= '0;
    end else begin
      r_wrt <= 1'b0;
      case (r_state)
        c_ST_IDLE, c_ST_DONE: begin
          if (i_load_start) begin
            r_state <= c_ST_RECV;
            r_addr  <= '0;
            r_count <= '0;
            r_error <= 1'b0;
          end
        end
        c_ST_RECV: begin
          if (bus.bus_valid) begin
            r_state <= c_ST_EMIT;
          end
        end
        c_ST_EMIT: begin
          r_wrt      <= 1'b1;
          r_wrt_addr <= r_addr;
          r_wrt_data <= w_wdata;
          r_count    <= r_count + 1'b1;
          if (w_is_term || w_overflow) begin
            r_state <= c_ST_DONE;
            r_error <= w_overflow;
          end else begin
            r_addr <= r_addr + 1'b1;
            if (w_last_lane) begin
              r_state <= c_ST_RECV;
            end
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

`ifdef INST_LOADER_CHECKSUM_EN
  logic [instLen-1:0] r_checksum;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (i_load_start && (r_state == c_ST_IDLE || r_state == c_ST_DONE)) begin
      r_checksum <= instLen'(peId);
    end else if (w_emit) begin
      r_checksum <= r_checksum ^ w_wdata;
    end
  end

  assign o_inst_checksum = r_checksum;
`endif

  assign bus.bus_ready     = (r_state == c_ST_RECV);
  assign o_inst_wrt        = r_wrt;
  assign o_inst_wrt_addr   = r_wrt_addr;
  assign o_inst_wrt_data   = r_wrt_data;
  assign o_load_busy       = (r_state == c_ST_RECV) || (r_state == c_ST_EMIT);
  assign o_load_done       = (r_state == c_ST_DONE);
  assign o_load_error      = r_error;
  assign o_inst_count      = r_count;

endmodule

`default_nettype wire

// File: tb/tb_pe_inst_loader.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_pe_inst_loader                                                |
// | Desc    : Scoreboard bench: A = 64-entry buffer, B = 8-entry buffer.       |
// | Rev     : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_pe_inst_loader;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic a_start, b_start;

  logic        a_wrt, b_wrt;
  logic [5:0]  a_addr;
  logic [2:0]  b_addr;
  logic [31:0] a_data, b_data;
  logic        a_busy, a_done, a_err, b_busy, b_done, b_err;
  logic [6:0]  a_cnt;
  logic [3:0]  b_cnt;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [31:0] a_csum, b_csum;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  pe_inst_bus_if #(.busLen(64)) bus_a ();
  pe_inst_bus_if #(.busLen(64)) bus_b ();

  pe_inst_loader #(.instAddrLen(6), .instLen(32), .busLen(64), .peId(5)) dut_a (
    .clk(clk), .reset(reset), .i_load_start(a_start), .bus(bus_a.slave),
    .o_inst_wrt(a_wrt), .o_inst_wrt_addr(a_addr), .o_inst_wrt_data(a_data),
    .o_load_busy(a_busy), .o_load_done(a_done), .o_load_error(a_err),
`ifdef INST_LOADER_CHECKSUM_EN
    .o_inst_checksum(a_csum),
`endif
    .o_inst_count(a_cnt)
  );

  pe_inst_loader #(.instAddrLen(3), .instLen(32), .busLen(64), .peId(5)) dut_b (
    .clk(clk), .reset(reset), .i_load_start(b_start), .bus(bus_b.slave),
    .o_inst_wrt(b_wrt), .o_inst_wrt_addr(b_addr), .o_inst_wrt_data(b_data),
    .o_load_busy(b_busy), .o_load_done(b_done), .o_load_error(b_err),
`ifdef INST_LOADER_CHECKSUM_EN
    .o_inst_checksum(b_csum),
`endif
    .o_inst_count(b_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_wrt === 1'b1) begin
      if (q_a.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_unexpected_write: got addr %0d data 0x%0h, expected no write", a_addr, a_data);
      end else begin
        e = q_a.pop_front();
        check("a_wrt_addr", 64'(a_addr), 64'(e.addr));
        check("a_wrt_data", 64'(a_data), 64'(e.data));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_wrt === 1'b1) begin
      if (q_b.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_unexpected_write: got addr %0d data 0x%0h, expected no write", b_addr, b_data);
      end else begin
        e = q_b.pop_front();
        check("b_wrt_addr", 64'(b_addr), 64'(e.addr));
        check("b_wrt_data", 64'(b_data), 64'(e.data));
      end
    end
  end

  task automatic push(input bit sel, input int addr, input logic [31:0] data);
    exp_t e;
    e.addr = 8'(addr);
    e.data = data;
    if (sel) q_b.push_back(e); else q_a.push_back(e);
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) b_start = 1'b1; else a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  // Holds the word until a handshake is committed, then checks bus_ready drops in EMIT.
  task automatic send_word(input bit sel, input logic [63:0] w, input bit rnd);
    int  budget = 200;
    bit  taken  = 1'b0;
    logic v;
    while (!taken && budget > 0) begin
      @(negedge clk);
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (sel) begin bus_b.bus_valid = v; bus_b.bus_data = w; end
      else     begin bus_a.bus_valid = v; bus_a.bus_data = w; end
      if (v && (sel ? bus_b.bus_ready : bus_a.bus_ready)) taken = 1'b1;
      budget--;
    end
    if (!taken) begin
      n_checks++; n_fail++;
      $display("FAIL send_word_timeout: got no handshake, expected one for 0x%0h", w);
    end
    @(negedge clk);
    bus_a.bus_valid = 1'b0;
    bus_b.bus_valid = 1'b0;
    check("ready_low_in_emit", 64'(sel ? bus_b.bus_ready : bus_a.bus_ready), 64'd0);
  endtask

  task automatic wait_done(input bit sel);
    int budget = 100;
    while (!(sel ? b_done : a_done) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_checks++; n_fail++;
      $display("FAIL wait_done_timeout: got load_done 0, expected 1");
    end
  endtask

  task automatic check_a_idle_zero(input string tag);
    check({tag, "_ready"}, 64'(bus_a.bus_ready), 64'd0);
    check({tag, "_wrt"},   64'(a_wrt),  64'd0);
    check({tag, "_addr"},  64'(a_addr), 64'd0);
    check({tag, "_data"},  64'(a_data), 64'd0);
    check({tag, "_busy"},  64'(a_busy), 64'd0);
    check({tag, "_done"},  64'(a_done), 64'd0);
    check({tag, "_err"},   64'(a_err),  64'd0);
    check({tag, "_cnt"},   64'(a_cnt),  64'd0);
`ifdef INST_LOADER_CHECKSUM_EN
    check({tag, "_csum"},  64'(a_csum), 64'd0);
`endif
  endtask

  task automatic scen1(input string tag);
    pulse_start(1'b0);
    push(1'b0, 0, 32'h1111_0001);
    push(1'b0, 1, 32'h0);
    send_word(1'b0, 64'h0000_0000_1111_0001, 1'b0);
    wait_done(1'b0);
    check({tag, "_done"}, 64'(a_done), 64'd1);
    check({tag, "_cnt"},  64'(a_cnt),  64'd2);
    check({tag, "_err"},  64'(a_err),  64'd0);
    check({tag, "_busy"}, 64'(a_busy), 64'd0);
`ifdef INST_LOADER_CHECKSUM_EN
    check({tag, "_csum"}, 64'(a_csum), 64'h1111_0004);
`endif
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit rdy_seen;
    reset = 1'b1;
    a_start = 1'b0;
    b_start = 1'b0;
    bus_a.bus_valid = 1'b0; bus_a.bus_data = '0;
    bus_b.bus_valid = 1'b0; bus_b.bus_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_a_idle_zero("rst");
    check("rst_b_ready", 64'(bus_b.bus_ready), 64'd0);

    // bus_valid outside RECV must be ignored
    bus_a.bus_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready", 64'(bus_a.bus_ready), 64'd0);
    bus_a.bus_valid = 1'b0;

    scen1("s1");

    // Terminator in lane 0 discards lane 1
    pulse_start(1'b0);
    check("s2_busy", 64'(a_busy), 64'd1);
    push(1'b0, 0, 32'h0);
    send_word(1'b0, 64'hAAAA_0003_0000_0000, 1'b0);
    wait_done(1'b0);
    repeat (3) @(negedge clk);
    check("s2_done", 64'(a_done), 64'd1);
    check("s2_cnt",  64'(a_cnt),  64'd1);
`ifdef INST_LOADER_CHECKSUM_EN
    check("s2_csum", 64'(a_csum), 64'h5);
`endif

    // Three words with ragged bus_valid
    pulse_start(1'b0);
    for (int i = 0; i < 5; i++) push(1'b0, i, 32'(i + 1));
    push(1'b0, 5, 32'h0);
    send_word(1'b0, 64'h0000_0002_0000_0001, 1'b1);
    send_word(1'b0, 64'h0000_0004_0000_0003, 1'b1);
    send_word(1'b0, 64'h0000_0000_0000_0005, 1'b1);
    wait_done(1'b0);
    check("s3_cnt", 64'(a_cnt), 64'd6);
    check("s3_err", 64'(a_err), 64'd0);
`ifdef INST_LOADER_CHECKSUM_EN
    check("s3_csum", 64'(a_csum), 64'h4);
`endif

    // Overflow on the 8-entry buffer
    pulse_start(1'b1);
    for (int i = 0; i < 7; i++) push(1'b1, i, 32'(i + 1));
    push(1'b1, 7, 32'h0);
    for (int i = 0; i < 4; i++) send_word(1'b1, {32'(2 * i + 2), 32'(2 * i + 1)}, 1'b0);
    wait_done(1'b1);
    check("s4_err",  64'(b_err),  64'd1);
    check("s4_cnt",  64'(b_cnt),  64'd8);
    rdy_seen = 1'b0;
    bus_b.bus_valid = 1'b1;
    bus_b.bus_data  = 64'h0000_000A_0000_0009;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_b.bus_ready) rdy_seen = 1'b1;
    end
    bus_b.bus_valid = 1'b0;
    check("s4_no_extra_accept", 64'(rdy_seen), 64'd0);
    check("s4_done_hold", 64'(b_done), 64'd1);
    check("s4_err_sticky", 64'(b_err), 64'd1);
    pulse_start(1'b1);
    check("s4_err_clear", 64'(b_err),  64'd0);
    check("s4_cnt_clear", 64'(b_cnt),  64'd0);
    check("s4_done_clear", 64'(b_done), 64'd0);

    // Reset in EMIT after the first write
    pulse_start(1'b0);
    push(1'b0, 0, 32'h0000_0011);
    send_word(1'b0, 64'h0000_0022_0000_0011, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_a_idle_zero("s5");
    reset = 1'b0;
    @(negedge clk);
    scen1("s5_reload");

    repeat (4) @(negedge clk);
    check("q_a_empty", 64'(q_a.size()), 64'd0);
    check("q_b_empty", 64'(q_b.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
